// File: rtl/cci_mpf_csr_event_counters.sv
// MPF shim event counters: registers single-cycle event pulses, sums them into
// per-event counters with sticky overflow flags, and serves a fixed-latency read port.
module cci_mpf_csr_event_counters #(
  parameter int unsigned NUM_EVENTS    = 7,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned IDX_WIDTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  rd_req,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic                  rd_rsp_valid,
  output logic [63:0]           rd_rsp_data,
  input  logic                  clr_valid,
  input  logic                  clr_all,
  input  logic [IDX_WIDTH-1:0]  clr_idx
);

  localparam int unsigned DATA_WIDTH = 64;
  localparam logic [IDX_WIDTH-1:0] OVF_IDX = IDX_WIDTH'(NUM_EVENTS);

  logic [NUM_EVENTS-1:0]    ev_q;
  logic [NUM_EVENTS-1:0]    ovf;
  logic [NUM_EVENTS-1:0]    clr_hit;
  logic [COUNTER_WIDTH-1:0] cnt [NUM_EVENTS];

  logic                     clr_q_valid;
  logic                     clr_q_all;
  logic [IDX_WIDTH-1:0]     clr_q_idx;
  logic                     rd_q_valid;
  logic [IDX_WIDTH-1:0]     rd_q_idx;
  logic [DATA_WIDTH-1:0]    rd_sel;

  // Input stage: events, clear command and read request all land one edge in.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_q        <= '0;
      clr_q_valid <= 1'b0;
      clr_q_all   <= 1'b0;
      clr_q_idx   <= '0;
      rd_q_valid  <= 1'b0;
      rd_q_idx    <= '0;
    end else begin
      ev_q        <= events;
      clr_q_valid <= clr_valid;
      clr_q_all   <= clr_all;
      clr_q_idx   <= clr_idx;
      rd_q_valid  <= rd_req;
      rd_q_idx    <= rd_idx;
    end
  end

  // Out-of-range single clears match no counter and are dropped here.
  always_comb begin
    clr_hit = '0;
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      clr_hit[i] = clr_q_valid && (clr_q_all || (clr_q_idx == IDX_WIDTH'(i)));
    end
  end

  // A cleared counter restarts at its pending event bit so no pulse is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= '0;
      for (int i = 0; i < int'(NUM_EVENTS); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_EVENTS); i++) begin
        if (clr_hit[i]) begin
          cnt[i] <= COUNTER_WIDTH'(ev_q[i]);
          ovf[i] <= 1'b0;
        end else if (ev_q[i]) begin
          cnt[i] <= cnt[i] + COUNTER_WIDTH'(1);
          if (&cnt[i]) begin
            ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read select: counters, then the overflow bitmap, zero beyond.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      if (rd_q_idx == IDX_WIDTH'(i)) begin
        rd_sel = DATA_WIDTH'(cnt[i]);
      end
    end
    if (rd_q_idx == OVF_IDX) begin
      rd_sel = DATA_WIDTH'(ovf);
    end
  end

  // Response register; data holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= rd_q_valid;
      if (rd_q_valid) begin
        rd_rsp_data <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
// Scoreboard bench for the MPF event counters (8-bit counters so wrap is reachable):
// directed scenarios with fixed expectations plus a randomized phase against a reference model.
module tb_cci_mpf_csr_event_counters;

  localparam int NE   = 7;
  localparam int CW   = 8;
  localparam int IW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NE-1:0] events;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic          rd_rsp_valid;
  logic [63:0]   rd_rsp_data;
  logic          clr_valid;
  logic          clr_all;
  logic [IW-1:0] clr_idx;

  // Directed-expectation side channel travelling with each read request.
  logic          rd_has_const;
  logic [63:0]   rd_const;

  cci_mpf_csr_event_counters #(
    .NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .events(events),
    .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .clr_valid(clr_valid), .clr_all(clr_all), .clr_idx(clr_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] exp;
    int          issue;
    bit          has_c;
    logic [63:0] cval;
  } rsp_t;

  rsp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rst_seen = 1'b0;

  // Reference model state: counts as plain integers, overflow as flags.
  int   m_cnt [NE];
  bit   m_ovf [NE];
  bit   m_pend_ev [NE];
  bit   m_pend_clr_v;
  bit   m_pend_clr_all;
  int   m_pend_clr_idx;

  function automatic logic [63:0] model_value(int idx);
    logic [63:0] v;
    v = '0;
    if (idx < NE) v = 64'(m_cnt[idx]);
    else if (idx == NE) for (int i = 0; i < NE; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // Model: one step per clock edge; a read captured at an edge sees the counts after that edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < NE; i++) begin
          m_cnt[i] = 0; m_ovf[i] = 0; m_pend_ev[i] = 0;
        end
        m_pend_clr_v = 0;
        q.delete();
        rst_seen = 1'b1;
      end else begin
        rst_seen = 1'b0;
        for (int i = 0; i < NE; i++) begin
          if (m_pend_clr_v && (m_pend_clr_all || m_pend_clr_idx == i)) begin
            m_cnt[i] = m_pend_ev[i] ? 1 : 0;
            m_ovf[i] = 0;
          end else if (m_pend_ev[i]) begin
            if (m_cnt[i] == MAXV) m_ovf[i] = 1;
            m_cnt[i] = (m_cnt[i] + 1) % (MAXV + 1);
          end
        end
        for (int i = 0; i < NE; i++) m_pend_ev[i] = events[i];
        m_pend_clr_v   = clr_valid;
        m_pend_clr_all = clr_all;
        m_pend_clr_idx = int'(clr_idx);
        if (rd_req) begin
          rsp_t e;
          e.exp   = model_value(int'(rd_idx));
          e.issue = cyc;
          e.has_c = rd_has_const;
          e.cval  = rd_const;
          q.push_back(e);
        end
      end
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response, checks hold value otherwise.
  initial begin
    logic [63:0] hold_exp;
    rsp_t e;
    hold_exp = '0;
    wait (cyc > 0);
    forever begin
      @(negedge clk);
      if (rst_seen) hold_exp = '0;
      if (rd_rsp_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rd_rsp_valid=1 data 0x%0h with nothing outstanding (cycle %0d)",
                   rd_rsp_data, cyc);
        end else begin
          e = q.pop_front();
          chk("rsp_data", rd_rsp_data, e.exp);
          chk("rsp_latency", 64'(cyc - e.issue), 64'd2);
          if (e.has_c) chk("rsp_directed", rd_rsp_data, e.cval);
          hold_exp = e.exp;
        end
      end else begin
        chk("rsp_valid_known", 64'(rd_rsp_valid), 64'd0);
        chk("rsp_hold", rd_rsp_data, hold_exp);
        if (q.size() > 0 && (cyc - q[0].issue) >= 2) begin
          checks++;
          errors++;
          $display("FAIL missing_rsp: no response for request issued at cycle %0d (now %0d)",
                   q[0].issue, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic [NE-1:0] ev);
    events = ev;
    step();
    events = '0;
  endtask

  task automatic rd(input int idx, input bit has_c, input logic [63:0] cval);
    rd_req = 1'b1; rd_idx = IW'(idx); rd_has_const = has_c; rd_const = cval;
    step();
    rd_req = 1'b0; rd_has_const = 1'b0;
  endtask

  task automatic clear(input bit all, input int idx);
    clr_valid = 1'b1; clr_all = all; clr_idx = IW'(idx);
    step();
    clr_valid = 1'b0; clr_all = 1'b0;
  endtask

  initial begin
    int idx6[4];
    logic [63:0] val6[4];
    reset = 1'b1; events = '0; rd_req = 1'b0; rd_idx = '0;
    clr_valid = 1'b0; clr_all = 1'b0; clr_idx = '0;
    rd_has_const = 1'b0; rd_const = '0;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Reset mid-stream with a read in flight.
    for (int i = 0; i < 20; i++) pulse(NE'($urandom));
    rd(0, 1'b0, '0);
    reset = 1'b1;
    idle(4);
    reset = 1'b0;
    for (int i = 0; i <= NE; i++) rd(i, 1'b1, 64'd0);
    idle(3);

    // Counting: non-contiguous and back-to-back pulses.
    for (int i = 0; i < 5; i++) begin pulse(7'h01); idle(2); end
    repeat (3) begin events = 7'h08; step(); end
    events = '0;
    idle(2);
    rd(0, 1'b1, 64'd5);
    idle(1);
    rd(3, 1'b1, 64'd3);
    idle(3);

    // Wrap of an 8-bit counter sets its sticky overflow bit.
    events = 7'h02;
    repeat (256) step();
    events = '0;
    idle(2);
    rd(1, 1'b1, 64'd0);
    rd(7, 1'b1, 64'h02);
    pulse(7'h02);
    idle(2);
    rd(1, 1'b1, 64'd1);
    rd(7, 1'b1, 64'h02);
    idle(3);

    // Clear racing an event on the same counter.
    for (int i = 0; i < 10; i++) begin pulse(7'h04); idle(1); end
    idle(2);
    rd(2, 1'b1, 64'd10);
    events = 7'h04;
    clear(1'b0, 2);
    events = '0;
    idle(3);
    rd(2, 1'b1, 64'd1);
    // Same-cycle read and clear returns the pre-clear value.
    rd_req = 1'b1; rd_idx = 4'd2; rd_has_const = 1'b1; rd_const = 64'd1;
    clear(1'b0, 2);
    rd_req = 1'b0; rd_has_const = 1'b0;
    idle(2);
    rd(2, 1'b1, 64'd0);
    // Out-of-range clear index is ignored.
    clear(1'b0, 12);
    idle(2);
    rd(0, 1'b1, 64'd5);
    idle(3);

    // Clear-all with every counter non-zero and every overflow bit set.
    events = 7'h7f;
    repeat (260) step();
    events = '0;
    idle(2);
    rd(7, 1'b1, 64'h7f);
    rd(0, 1'b1, 64'd9);
    clear(1'b1, 0);
    idle(2);
    for (int i = 0; i <= NE; i++) rd(i, 1'b1, 64'd0);
    idle(3);

    // Back-to-back pipelined reads, including an out-of-range index.
    pulse(7'h40); idle(1); pulse(7'h41); idle(2);
    idx6 = '{6, 0, 9, 7};
    val6 = '{64'd2, 64'd1, 64'd0, 64'd0};
    for (int i = 0; i < 4; i++) rd(idx6[i], 1'b1, val6[i]);
    idle(3);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      events    = NE'($urandom) & NE'($urandom) & NE'($urandom);
      rd_req    = ($urandom_range(0, 1) == 1);
      rd_idx    = IW'($urandom_range(0, 15));
      clr_valid = ($urandom_range(0, 99) < 2);
      clr_all   = ($urandom_range(0, 3) == 0);
      clr_idx   = IW'($urandom_range(0, 15));
      reset     = ($urandom_range(0, 999) < 2);
      step();
    end
    events = '0; rd_req = 1'b0; clr_valid = 1'b0; clr_all = 1'b0; reset = 1'b0;
    idle(5);
    chk("drain", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
